// File: rtl/piano_key_scheduler.sv
// Piano tone path: key sync/debounce, last-pressed arbitration, shared tone divider.
// Optional macro PIANO_SUSTAIN_EN adds a SUSTAIN state that holds the tone after release.
module piano_key_scheduler #(
   parameter int HALF0           = 25000,
   parameter int HALF1           = 12500,
   parameter int HALF2           = 6250,
   parameter int HALF3           = 3125,
   parameter int CNT_W           = 16,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int SUSTAIN_CYCLES  = 50000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [3:0] i_keys,
   output logic       o_speaker,
   output logic       o_active,
   output logic [1:0] o_note,
   output logic [3:0] o_keys_db
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PLAY
`ifdef PIANO_SUSTAIN_EN
      , S_SUSTAIN
`endif
   } state_t;

   state_t state, state_next;

   logic [3:0]      sync1, sync2, db_q;
   logic [DB_W-1:0] db_cnt [4];
   logic [3:0]      rise;
   logic [1:0]      note_next;
   logic [CNT_W-1:0] tone_cnt, half_m1;
   logic            restart;

   function automatic logic [1:0] lowest(input logic [3:0] v);
      logic [1:0] r;
      r = 2'd0;
      if (v[0])      r = 2'd0;
      else if (v[1]) r = 2'd1;
      else if (v[2]) r = 2'd2;
      else if (v[3]) r = 2'd3;
      return r;
   endfunction

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sync1     <= '0;
         sync2     <= '0;
         o_keys_db <= '0;
         db_q      <= '0;
         for (int n = 0; n < 4; n++) db_cnt[n] <= '0;
      end else begin
         sync1 <= i_keys;
         sync2 <= sync1;
         db_q  <= o_keys_db;
         for (int n = 0; n < 4; n++) begin
            if (sync2[n] == o_keys_db[n]) begin
               db_cnt[n] <= '0;
            end else if (db_cnt[n] == DB_MAX) begin
               db_cnt[n]    <= '0;
               o_keys_db[n] <= sync2[n];
            end else begin
               db_cnt[n] <= db_cnt[n] + 1'b1;
            end
         end
      end
   end

   assign rise = o_keys_db & ~db_q;

   // A fresh press always wins; a fall of the sounding key hands over to a held one.
   always_comb begin
      note_next = o_note;
      if (|rise)
         note_next = lowest(rise);
      else if (!o_keys_db[o_note] && |o_keys_db)
         note_next = lowest(o_keys_db);
   end

`ifdef PIANO_SUSTAIN_EN
   localparam int SUS_W = (SUSTAIN_CYCLES > 2) ? $clog2(SUSTAIN_CYCLES) : 1;
   localparam logic [SUS_W-1:0] SUS_MAX = SUS_W'(SUSTAIN_CYCLES - 1);
   logic [SUS_W-1:0] sus_cnt;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         sus_cnt <= '0;
      else if (state == S_SUSTAIN && state_next == S_SUSTAIN)
         sus_cnt <= sus_cnt + 1'b1;
      else
         sus_cnt <= '0;
   end
`endif

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:
            if (|o_keys_db) state_next = S_PLAY;
         S_PLAY:
`ifdef PIANO_SUSTAIN_EN
            if (!(|o_keys_db)) state_next = S_SUSTAIN;
         S_SUSTAIN:
            if (|rise)                  state_next = S_PLAY;
            else if (sus_cnt == SUS_MAX) state_next = S_IDLE;
`else
            if (!(|o_keys_db)) state_next = S_IDLE;
`endif
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state  <= S_IDLE;
         o_note <= 2'd0;
      end else begin
         state  <= state_next;
         o_note <= note_next;
      end
   end

   assign o_active = (state != S_IDLE);

   always_comb begin
      half_m1 = CNT_W'(HALF0 - 1);
      unique case (o_note)
         2'd0: half_m1 = CNT_W'(HALF0 - 1);
         2'd1: half_m1 = CNT_W'(HALF1 - 1);
         2'd2: half_m1 = CNT_W'(HALF2 - 1);
         2'd3: half_m1 = CNT_W'(HALF3 - 1);
         default: half_m1 = CNT_W'(HALF0 - 1);
      endcase
   end

   // New note or fresh start begins on a clean low half-period.
   assign restart = (state == S_IDLE) || (note_next != o_note);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         tone_cnt  <= '0;
         o_speaker <= 1'b0;
      end else if (state_next == S_IDLE || restart) begin
         tone_cnt  <= '0;
         o_speaker <= 1'b0;
      end else if (tone_cnt == half_m1) begin
         tone_cnt  <= '0;
         o_speaker <= ~o_speaker;
      end else begin
         tone_cnt <= tone_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_piano_key_scheduler.sv
// Directed bench for piano_key_scheduler (HALF 4/6/8/10, debounce 4, sustain 20).
module tb_piano_key_scheduler;

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic [3:0] i_keys;
   logic       o_speaker;
   logic       o_active;
   logic [1:0] o_note;
   logic [3:0] o_keys_db;

   int n_cmp = 0;
   int n_bad = 0;

   piano_key_scheduler #(
      .HALF0(4), .HALF1(6), .HALF2(8), .HALF3(10),
      .CNT_W(16), .DEBOUNCE_CYCLES(4), .SUSTAIN_CYCLES(20)
   ) dut (
      .i_clk(i_clk),
      .i_reset(i_reset),
      .i_keys(i_keys),
      .o_speaker(o_speaker),
      .o_active(o_active),
      .o_note(o_note),
      .o_keys_db(o_keys_db)
   );

   always #5 i_clk = ~i_clk;

   task automatic step(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      i_reset = 1'b1;
      i_keys  = 4'b0000;
      #12;
      chk("rst_spk", 32'(o_speaker), 0);
      chk("rst_act", 32'(o_active), 0);
      chk("rst_note", 32'(o_note), 0);
      chk("rst_db", 32'(o_keys_db), 0);
      step(1);
      i_reset = 1'b0;
      step(1);

      // key 2 held
      i_keys = 4'b0100;
      step(5);
      chk("k2_db_e5", 32'(o_keys_db), 0);
      step(1);
      chk("k2_db_e6", 32'(o_keys_db), 32'h4);
      chk("k2_act_e6", 32'(o_active), 0);
      step(1);
      chk("k2_act_e7", 32'(o_active), 1);
      chk("k2_note", 32'(o_note), 2);
      chk("k2_spk_e7", 32'(o_speaker), 0);
      step(7);
      chk("k2_spk_e14", 32'(o_speaker), 0);
      step(1);
      chk("k2_spk_e15", 32'(o_speaker), 1);
      step(7);
      chk("k2_spk_e22", 32'(o_speaker), 1);
      step(1);
      chk("k2_spk_e23", 32'(o_speaker), 0);

      // release key 2
      i_keys = 4'b0000;
      step(6);
      chk("rel_db", 32'(o_keys_db), 0);
      chk("rel_act_e6", 32'(o_active), 1);
      step(1);
`ifdef PIANO_SUSTAIN_EN
      chk("sus_act_e7", 32'(o_active), 1);
      i_keys = 4'b0100;
      step(30);
      chk("sus_repress_act", 32'(o_active), 1);
      chk("sus_repress_note", 32'(o_note), 2);
      i_keys = 4'b0000;
      step(40);
      chk("sus_end_act", 32'(o_active), 0);
      chk("sus_end_spk", 32'(o_speaker), 0);
`else
      chk("rel_act_e7", 32'(o_active), 0);
      chk("rel_spk_e7", 32'(o_speaker), 0);
      step(25);
      chk("rel_act_late", 32'(o_active), 0);
`endif
      chk("idle_note_hold", 32'(o_note), 2);

      // bouncing short pulse on key 0
      i_keys = 4'b0001;
      step(1);
      i_keys = 4'b0000;
      step(1);
      i_keys = 4'b0001;
      step(1);
      i_keys = 4'b0000;
      step(10);
      chk("bounce_db", 32'(o_keys_db), 0);
      chk("bounce_act", 32'(o_active), 0);

      // key 3, then key 1 added, then key 1 released
      i_keys = 4'b1000;
      step(7);
      chk("k3_act", 32'(o_active), 1);
      chk("k3_note", 32'(o_note), 3);
      i_keys = 4'b1010;
      step(6);
      chk("k31_note_e6", 32'(o_note), 3);
      step(1);
      chk("k31_note_e7", 32'(o_note), 1);
      chk("k31_spk_e7", 32'(o_speaker), 0);
      step(5);
      chk("k31_spk_e12", 32'(o_speaker), 0);
      step(1);
      chk("k31_spk_e13", 32'(o_speaker), 1);
      step(6);
      chk("k31_spk_e19", 32'(o_speaker), 0);
      i_keys = 4'b1000;
      step(7);
      chk("k1rel_note", 32'(o_note), 3);
      chk("k1rel_spk_e7", 32'(o_speaker), 0);
      step(9);
      chk("k1rel_spk_e16", 32'(o_speaker), 0);
      step(1);
      chk("k1rel_spk_e17", 32'(o_speaker), 1);

      // simultaneous rises on keys 1 and 2
      i_keys = 4'b0000;
      step(40);
      chk("sim_idle", 32'(o_active), 0);
      i_keys = 4'b0110;
      step(7);
      chk("sim_note", 32'(o_note), 1);
      chk("sim_act", 32'(o_active), 1);
      step(6);
      chk("sim_spk_e13", 32'(o_speaker), 1);

      // asynchronous reset mid-tone
      #2;
      i_reset = 1'b1;
      #1;
      chk("arst_spk", 32'(o_speaker), 0);
      chk("arst_act", 32'(o_active), 0);
      chk("arst_note", 32'(o_note), 0);
      chk("arst_db", 32'(o_keys_db), 0);
      step(2);
      i_reset = 1'b0;
      step(5);
      chk("redb_e5", 32'(o_keys_db), 0);
      step(1);
      chk("redb_e6", 32'(o_keys_db), 32'h6);
      step(1);
      chk("redb_act", 32'(o_active), 1);
      chk("redb_note", 32'(o_note), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
